// File: rtl/fir_tap_loader_if.sv
// Host config/command port and FIR tap stream of the tap loader.
// master = loader side, slave = host/FIR side.
interface fir_tap_loader_if #(
    parameter int G_ADDR_W = 4,
    parameter int G_DATA_W = 16
);
    logic [G_ADDR_W-1:0] cfg_wr_addr;
    logic [G_DATA_W-1:0] cfg_wr_data;
    logic                cfg_wr_valid;
    logic                cfg_wr_ready;
    logic                load_start;
    logic                busy;
    logic                load_done;
    logic                load_err;
    logic [G_DATA_W-1:0] tap_dout;
    logic                tap_dout_valid;
    logic                tap_dout_ready;
    logic                fir_done;

    modport master (
        input  cfg_wr_addr, cfg_wr_data, cfg_wr_valid, load_start, tap_dout_ready, fir_done,
        output cfg_wr_ready, busy, load_done, load_err, tap_dout, tap_dout_valid
    );

    modport slave (
        output cfg_wr_addr, cfg_wr_data, cfg_wr_valid, load_start, tap_dout_ready, fir_done,
        input  cfg_wr_ready, busy, load_done, load_err, tap_dout, tap_dout_valid
    );
endinterface

// File: rtl/fir_tap_loader.sv
// Coefficient table + streamer: on load_start pushes all taps to the FIR, first tap valid 3 edges
// after load_start; read pipeline stalls behind a 1-entry skid so tap_dout_ready only gates registers.
module fir_tap_loader #(
    parameter int G_NUM_TAPS_LOG2 = 4,
    parameter int G_TAP_WIDTH     = 16,
    parameter int G_REVERSE       = 0,
    parameter int G_DONE_TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    fir_tap_loader_if.master bus
);
    localparam int AW = G_NUM_TAPS_LOG2;
    localparam int DW = G_TAP_WIDTH;
    localparam int CW = (G_DONE_TIMEOUT > 0) ? $clog2(G_DONE_TIMEOUT + 1) : 1;
    localparam logic [AW-1:0] IDX_FIRST = (G_REVERSE != 0) ? '1 : '0;
    localparam logic [AW-1:0] IDX_LAST  = (G_REVERSE != 0) ? '0 : '1;
    localparam logic [CW-1:0] TO_LAST   = CW'((G_DONE_TIMEOUT > 0) ? G_DONE_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic            load_done_q, load_done_d, load_err_q, load_err_d;
    logic [DW-1:0]   mem_q [2**AW];
    logic [AW-1:0]   idx_q, rd_addr_q, hs_cnt_q;
    logic            iss_end_q, rd_vld_q, dat_vld_q, out_vld_q, sk_vld_q;
    logic [DW-1:0]   dat_q, out_q, sk_q;
    logic [CW-1:0]   to_cnt_q;
    logic            wr_fire, adv, in_vld, hs, last_hs;

    assign wr_fire = bus.cfg_wr_valid && bus.cfg_wr_ready;
    assign adv     = !sk_vld_q;
    assign in_vld  = adv && dat_vld_q;
    assign hs      = out_vld_q && bus.tap_dout_ready;
    assign last_hs = hs && (hs_cnt_q == '1);

    always_comb begin
        state_d     = state_q;
        load_done_d = 1'b0;
        load_err_d  = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (bus.load_start) state_d = S_FETCH;
                S_FETCH:  state_d = S_STREAM;
                S_STREAM: begin
                    if (last_hs) begin
                        if (G_DONE_TIMEOUT == 0) begin
                            state_d     = S_IDLE;
                            load_done_d = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.fir_done) begin
                        state_d     = S_IDLE;
                        load_done_d = 1'b1;
                    end else if (to_cnt_q == TO_LAST) begin
                        state_d    = S_IDLE;
                        load_err_d = 1'b1;
                    end
                end
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            to_cnt_q    <= (state_q == S_WAIT && state_d == S_WAIT) ? to_cnt_q + 1'b1 : '0;
        end
    end

    // Table is deliberately not reset; it is a BRAM and survives reset/enable.
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[bus.cfg_wr_addr] <= bus.cfg_wr_data;
        if (adv)     dat_q <= mem_q[rd_addr_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q     <= '0;
            rd_addr_q <= '0;
            hs_cnt_q  <= '0;
            iss_end_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            dat_vld_q <= 1'b0;
            out_vld_q <= 1'b0;
            sk_vld_q  <= 1'b0;
            out_q     <= '0;
            sk_q      <= '0;
        end else if (state_d == S_FETCH) begin
            idx_q     <= IDX_FIRST;
            hs_cnt_q  <= '0;
            iss_end_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            dat_vld_q <= 1'b0;
            out_vld_q <= 1'b0;
            sk_vld_q  <= 1'b0;
            out_q     <= '0;
        end else if (state_d != S_STREAM) begin
            rd_vld_q  <= 1'b0;
            dat_vld_q <= 1'b0;
            out_vld_q <= 1'b0;
            sk_vld_q  <= 1'b0;
            out_q     <= '0;
        end else begin
            // Whole read pipeline advances only while the skid is empty.
            if (adv) begin
                rd_vld_q  <= !iss_end_q;
                rd_addr_q <= idx_q;
                dat_vld_q <= rd_vld_q;
                if (!iss_end_q) begin
                    if (idx_q == IDX_LAST) iss_end_q <= 1'b1;
                    else if (G_REVERSE != 0) idx_q <= idx_q - 1'b1;
                    else idx_q <= idx_q + 1'b1;
                end
            end
            if (!out_vld_q || hs) begin
                if (sk_vld_q) begin
                    out_q     <= sk_q;
                    out_vld_q <= 1'b1;
                    sk_vld_q  <= 1'b0;
                end else if (in_vld) begin
                    out_q     <= dat_q;
                    out_vld_q <= 1'b1;
                end else begin
                    out_vld_q <= 1'b0;
                end
            end else if (in_vld) begin
                sk_q     <= dat_q;
                sk_vld_q <= 1'b1;
            end
            if (hs) hs_cnt_q <= hs_cnt_q + 1'b1;
        end
    end

    assign bus.cfg_wr_ready   = (state_q == S_IDLE) && enable;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.load_done      = load_done_q;
    assign bus.load_err       = load_err_q;
    assign bus.tap_dout       = out_q;
    assign bus.tap_dout_valid = out_vld_q;
endmodule

// File: tb/tb_fir_tap_loader.sv
// Scoreboard bench: forward (index 0) and reversed (index 1) loaders driven with identical stimulus.
module tb_fir_tap_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic cfg_vld = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [15:0] cfg_dat = '0;
    logic load_start = 1'b0;
    logic rdy = 1'b1;
    logic fir_done = 1'b0;

    always #5 clk = ~clk;

    fir_tap_loader_if #(.G_ADDR_W(4), .G_DATA_W(16)) bf ();
    fir_tap_loader_if #(.G_ADDR_W(4), .G_DATA_W(16)) br ();

    assign bf.cfg_wr_addr = cfg_addr;   assign br.cfg_wr_addr = cfg_addr;
    assign bf.cfg_wr_data = cfg_dat;    assign br.cfg_wr_data = cfg_dat;
    assign bf.cfg_wr_valid = cfg_vld;   assign br.cfg_wr_valid = cfg_vld;
    assign bf.load_start = load_start;  assign br.load_start = load_start;
    assign bf.tap_dout_ready = rdy;     assign br.tap_dout_ready = rdy;
    assign bf.fir_done = fir_done;      assign br.fir_done = fir_done;

    fir_tap_loader #(.G_NUM_TAPS_LOG2(4), .G_TAP_WIDTH(16), .G_REVERSE(0), .G_DONE_TIMEOUT(255))
        u_fwd (.clk(clk), .reset(reset), .enable(enable), .bus(bf));
    fir_tap_loader #(.G_NUM_TAPS_LOG2(4), .G_TAP_WIDTH(16), .G_REVERSE(1), .G_DONE_TIMEOUT(255))
        u_rev (.clk(clk), .reset(reset), .enable(enable), .bus(br));

    int n_chk = 0;
    int n_err = 0;
    int edges = 0;
    int ls_edge = 0;
    int pat_mode = 0;
    logic [15:0] tbl [16];
    logic [15:0] expq0 [$];
    logic [15:0] expq1 [$];
    int hs_n [2], first_vld [2], first_hs [2], last_hs [2];
    int done_cnt [2], err_cnt [2], err_edge [2];
    logic err_busy [2], prev_stall [2];
    logic [15:0] prev_dat [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        for (int k = 0; k < 2; k++) begin
            hs_n[k] = 0; first_vld[k] = -1; first_hs[k] = -1; last_hs[k] = -1;
            done_cnt[k] = 0; err_cnt[k] = 0; err_edge[k] = -1; err_busy[k] = 1'b1;
            prev_stall[k] = 1'b0; prev_dat[k] = '0;
        end
    endtask

    task automatic mon_one(input int k, input logic vld, input logic [15:0] dat,
                           input logic done, input logic err, input logic busy);
        logic [15:0] e;
        int sz;
        if (vld) begin
            if (first_vld[k] < 0) first_vld[k] = edges;
            if (prev_stall[k]) chk($sformatf("hold%0d", k), dat, prev_dat[k]);
            if (rdy) begin
                sz = (k == 0) ? expq0.size() : expq1.size();
                chk($sformatf("q_nonempty%0d", k), (sz > 0), 1);
                if (sz > 0) begin
                    e = (k == 0) ? expq0.pop_front() : expq1.pop_front();
                    chk($sformatf("tap%0d_%0d", k, hs_n[k]), dat, e);
                end
                hs_n[k]++;
                if (first_hs[k] < 0) first_hs[k] = edges + 1;
                last_hs[k] = edges + 1;
            end
        end
        prev_stall[k] = vld && !rdy;
        prev_dat[k] = dat;
        if (done) done_cnt[k]++;
        if (err) begin
            err_cnt[k]++;
            err_edge[k] = edges;
            err_busy[k] = busy;
        end
    endtask

    task automatic step();
        mon_one(0, bf.tap_dout_valid, bf.tap_dout, bf.load_done, bf.load_err, bf.busy);
        mon_one(1, br.tap_dout_valid, br.tap_dout, br.load_done, br.load_err, br.busy);
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    task automatic start_load();
        for (int i = 0; i < 16; i++) begin
            expq0.push_back(tbl[i]);
            expq1.push_back(tbl[15-i]);
        end
        ls_edge = edges + 1;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic wait_hs(input int n);
        logic [3:0] pat;
        int g;
        pat = 4'b1001;
        g = 0;
        while ((hs_n[0] < n || hs_n[1] < n) && g < 300) begin
            rdy = (pat_mode != 0) ? pat[g % 4] : 1'b1;
            step();
            g++;
        end
        chk("hs_cnt0", hs_n[0], n);
        chk("hs_cnt1", hs_n[1], n);
    endtask

    task automatic finish_done();
        repeat (4) step();
        fir_done = 1'b1;
        step();
        fir_done = 1'b0;
        repeat (2) step();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("done_cnt%0d", k), done_cnt[k], 1);
            chk($sformatf("err_cnt%0d", k), err_cnt[k], 0);
        end
        chk("busy_after_done0", bf.busy, 0);
        chk("busy_after_done1", br.busy, 0);
    endtask

    initial begin
        int g;
        clr();
        @(negedge clk);
        @(negedge clk);
        chk("rst_vld", bf.tap_dout_valid, 0);
        chk("rst_dout", bf.tap_dout, 0);
        chk("rst_busy", bf.busy, 0);
        chk("rst_done", bf.load_done, 0);
        chk("rst_err", br.load_err, 0);
        reset = 1'b0;
        step();
        chk("idle_wr_rdy", bf.cfg_wr_ready, 1);

        for (int k = 0; k < 16; k++) begin
            tbl[k] = 16'h0100 + 16'(k);
            cfg_vld = 1'b1; cfg_addr = 4'(k); cfg_dat = tbl[k];
            step();
        end
        cfg_vld = 1'b0;

        // basic stream, ready held high
        clr();
        start_load();
        wait_hs(16);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("lat%0d", k), first_vld[k] - ls_edge, 3);
            chk($sformatf("no_bubble%0d", k), last_hs[k] - first_hs[k], 15);
        end
        chk("vld_drop0", bf.tap_dout_valid, 0);
        chk("vld_drop1", br.tap_dout_valid, 0);
        chk("busy_wait", bf.busy, 1);
        finish_done();

        // ready pattern 1,0,0,1
        clr();
        pat_mode = 1;
        start_load();
        wait_hs(16);
        pat_mode = 0;
        rdy = 1'b1;
        repeat (6) step();
        chk("pat_hs_total", hs_n[0], 16);
        finish_done();

        // no fir_done: timeout
        clr();
        start_load();
        wait_hs(16);
        g = 0;
        while ((err_cnt[0] == 0 || err_cnt[1] == 0) && g < 400) begin
            step();
            g++;
        end
        step();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("to_dist%0d", k), err_edge[k] - last_hs[k], 255);
            chk($sformatf("to_busy%0d", k), err_busy[k], 0);
            chk($sformatf("to_err_cnt%0d", k), err_cnt[k], 1);
            chk($sformatf("to_done_cnt%0d", k), done_cnt[k], 0);
        end

        // async reset mid-stream, then replay
        clr();
        start_load();
        wait_hs(7);
        #2 reset = 1'b1;
        #1;
        chk("areset_vld0", bf.tap_dout_valid, 0);
        chk("areset_vld1", br.tap_dout_valid, 0);
        chk("areset_dout", bf.tap_dout, 0);
        chk("areset_busy", br.busy, 0);
        @(negedge clk);
        reset = 1'b0;
        expq0.delete();
        expq1.delete();
        step();
        clr();
        start_load();
        wait_hs(16);
        finish_done();

        // write and load_start while busy are ignored
        clr();
        rdy = 1'b0;
        start_load();
        repeat (4) step();
        cfg_vld = 1'b1; cfg_addr = 4'd3; cfg_dat = 16'hDEAD;
        load_start = 1'b1;
        chk("busy_wr_rdy", bf.cfg_wr_ready, 0);
        step();
        cfg_vld = 1'b0;
        load_start = 1'b0;
        wait_hs(16);
        repeat (4) step();
        chk("busy_ls_hs_total", hs_n[1], 16);
        finish_done();

        // write in the load_start cycle is streamed; tap 3 untouched
        clr();
        cfg_vld = 1'b1; cfg_addr = 4'd5; cfg_dat = 16'h0555;
        tbl[5] = 16'h0555;
        start_load();
        cfg_vld = 1'b0;
        wait_hs(16);
        finish_done();

        // enable drop aborts without pulses
        clr();
        start_load();
        wait_hs(4);
        enable = 1'b0;
        step();
        chk("abort_vld", bf.tap_dout_valid, 0);
        chk("abort_busy", br.busy, 0);
        chk("abort_dout", bf.tap_dout, 0);
        enable = 1'b1;
        expq0.delete();
        expq1.delete();
        repeat (3) step();
        chk("abort_done", done_cnt[0] + done_cnt[1], 0);
        chk("abort_err", err_cnt[0] + err_cnt[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
